// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the pipeline trace unit: flag positions, FSM states, record width.
// Honours TRACE_CYCLE_STAMP_EN (adds a cycle stamp field to every record).
package cpu_trace_pkg;

   localparam int FLAG_WB   = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_HALT = 2;
   localparam int FLAG_W    = 3;

`ifdef TRACE_CYCLE_STAMP_EN
   localparam bit STAMP_EN = 1'b1;
`else
   localparam bit STAMP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } trace_state_e;

   function automatic int trace_w(input int data_w, input int reg_w, input int cycle_w);
      return FLAG_W + 3 * data_w + reg_w + (STAMP_EN ? cycle_w : 0);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; head is visible whenever not empty, zero otherwise.
// Pointers carry one extra MSB so full/empty need no separate counter.
module trace_fifo #(
   parameter int W     = 55,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic [W-1:0] mem_q [DEPTH];

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // A write into a full FIFO targets the slot being popped in the same cycle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/pipeline_trace_unit.sv
// Samples IF/WB events of the 16-bit CPU, packs them into records and streams them out.
// TRACE_CYCLE_STAMP_EN appends a CYCLE_W-bit RUN-cycle stamp to each record.
module pipeline_trace_unit
   import cpu_trace_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4,
   parameter int DEPTH      = 8,
   parameter int CYCLE_W    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  trace_enable,
   input  logic [DATA_W-1:0]     if_pc,
   input  logic [DATA_W-1:0]     if_instruction,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0]     wb_write_data,
   input  logic                  halt,
   input  logic                  overflow_flag,
   output logic                  trace_valid,
   input  logic                  trace_ready,
   output logic [trace_w(DATA_W, REG_ADDR_W, CYCLE_W)-1:0] trace_data,
   output logic [7:0]            trace_dropped,
   output logic                  trace_done
);

   localparam int TRACE_W = trace_w(DATA_W, REG_ADDR_W, CYCLE_W);

   trace_state_e       state_q;
   logic               halt_q;
   logic               done_q;
   logic [7:0]         dropped_q;
   logic [FLAG_W-1:0]  flags;
   logic               capture, fifo_full, fifo_empty, pop, push, drop;
   logic [TRACE_W-1:0] record;

   assign flags[FLAG_WB]   = wb_reg_write;
   assign flags[FLAG_OVF]  = overflow_flag;
   assign flags[FLAG_HALT] = halt && !halt_q;

   assign capture = (state_q == ST_RUN) && (|flags);
   assign pop     = trace_valid && trace_ready;
   assign push    = capture && (!fifo_full || pop);
   assign drop    = capture && !push;

`ifdef TRACE_CYCLE_STAMP_EN
   logic [CYCLE_W-1:0] cycle_q;

   assign record = {flags, if_pc, if_instruction, wb_write_reg, wb_write_data, cycle_q};

   // Cleared on RUN entry so the first RUN cycle stamps 0; holds outside RUN.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                     cycle_q <= '0;
      else if (state_q == ST_IDLE && trace_enable)    cycle_q <= '0;
      else if (state_q == ST_RUN)                     cycle_q <= cycle_q + 1'b1;
   end
`else
   assign record = {flags, if_pc, if_instruction, wb_write_reg, wb_write_data};
`endif

   trace_fifo #(
      .W     (TRACE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clock),
      .rst_ni    (reset),
      .wr_en_i   (push),
      .wr_data_i (record),
      .rd_en_i   (pop),
      .rd_data_o (trace_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign trace_valid   = !fifo_empty;
   assign trace_dropped = dropped_q;
   assign trace_done    = done_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) halt_q <= 1'b0;
      else        halt_q <= halt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         done_q    <= 1'b0;
         dropped_q <= '0;
      end else begin
         if (drop && dropped_q != 8'hFF) dropped_q <= dropped_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (trace_enable) begin
                  state_q   <= ST_RUN;
                  dropped_q <= '0;
               end
            end
            ST_RUN: begin
               // A captured halt edge wins over trace_enable falling.
               if (capture && flags[FLAG_HALT]) state_q <= ST_DRAIN;
               else if (!trace_enable)          state_q <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!trace_enable) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed self-checking bench for pipeline_trace_unit (default parameters).
// Honours TRACE_CYCLE_STAMP_EN to match the record width and stamp field.
module tb_pipeline_trace_unit;

`ifdef TRACE_CYCLE_STAMP_EN
   localparam int TW = 71;
`else
   localparam int TW = 55;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          trace_enable;
   logic [15:0]   if_pc, if_instruction, wb_write_data;
   logic          wb_reg_write, halt, overflow_flag, trace_ready;
   logic [3:0]    wb_write_reg;
   logic          trace_valid, trace_done;
   logic [TW-1:0] trace_data;
   logic [7:0]    trace_dropped;

   logic [TW-1:0] exp_q[$];
   logic [TW-1:0] exp_rec;
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            exp_run = 1'b0;
   int            run_cnt = 0;

   pipeline_trace_unit dut (
      .clock          (clock),
      .reset          (reset),
      .trace_enable   (trace_enable),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .wb_reg_write   (wb_reg_write),
      .wb_write_reg   (wb_write_reg),
      .wb_write_data  (wb_write_data),
      .halt           (halt),
      .overflow_flag  (overflow_flag),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_data     (trace_data),
      .trace_dropped  (trace_dropped),
      .trace_done     (trace_done)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clock);
      if (exp_run) run_cnt++;
      #1;
   endtask

   task automatic drive(input logic wb, input logic ovf, input logic h,
                        input logic [15:0] pc, input logic [15:0] ins,
                        input logic [3:0] r, input logic [15:0] d);
      wb_reg_write   = wb;
      overflow_flag  = ovf;
      halt           = h;
      if_pc          = pc;
      if_instruction = ins;
      wb_write_reg   = r;
      wb_write_data  = d;
   endtask

   // Expected record; the stamp is the number of RUN edges before the capture edge.
   function automatic logic [TW-1:0] mk(input logic [2:0] f, input logic [15:0] pc,
                                        input logic [15:0] ins, input logic [3:0] r,
                                        input logic [15:0] d);
`ifdef TRACE_CYCLE_STAMP_EN
      return {f, pc, ins, r, d, 16'(run_cnt)};
`else
      return {f, pc, ins, r, d};
`endif
   endfunction

   initial begin
      reset        = 1'b0;
      trace_enable = 1'b1;
      trace_ready  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 16'h0);
      tick();
      tick();
      check("rst_valid",   64'(trace_valid),   64'd0);
      check("rst_data",    128'(trace_data),   128'd0);
      check("rst_dropped", 64'(trace_dropped), 64'd0);
      check("rst_done",    64'(trace_done),    64'd0);

      reset = 1'b1;
      tick();
      exp_run = 1'b1;
      run_cnt = 0;

      // Single WB event, valid for exactly one cycle with ready high.
      trace_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 16'h0004, 16'h1234, 4'd3, 16'h00A5);
      exp_rec = mk(3'b001, 16'h0004, 16'h1234, 4'd3, 16'h00A5);
      check("t1_pre_valid", 64'(trace_valid), 64'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 4'd0, 16'h0000);
      check("t1_valid", 64'(trace_valid), 64'd1);
      check("t1_data",  128'(trace_data), 128'(exp_rec));
      tick();
      check("t1_valid_off", 64'(trace_valid), 64'd0);

      // Coincident WB + overflow merge into one record.
      drive(1'b1, 1'b1, 1'b0, 16'h0008, 16'h5678, 4'd7, 16'hBEEF);
      exp_rec = mk(3'b011, 16'h0008, 16'h5678, 4'd7, 16'hBEEF);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 4'd0, 16'h0000);
      check("t2_data", 128'(trace_data), 128'(exp_rec));
      tick();
      check("t2_single", 64'(trace_valid), 64'd0);
      tick();
      check("no_flag_idle", 64'(trace_valid), 64'd0);

      // Ten events into a stalled 8-deep FIFO: two drops.
      trace_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i), 16'h2000 + 16'(i), 4'(i), 16'hA000 + 16'(i));
         if (i < 8) exp_q.push_back(mk(3'b001, 16'h0100 + 16'(i), 16'h2000 + 16'(i), 4'(i), 16'hA000 + 16'(i)));
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      check("ovf_dropped", 64'(trace_dropped), 64'd2);
      check("ovf_valid",   64'(trace_valid),   64'd1);

      // Full FIFO, pop and push in the same cycle: push accepted.
      trace_ready = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 16'h0200, 16'h3000, 4'd15, 16'hCAFE);
      check("full_head", 128'(trace_data), 128'(exp_q.pop_front()));
      exp_q.push_back(mk(3'b001, 16'h0200, 16'h3000, 4'd15, 16'hCAFE));
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      check("full_push_dropped", 64'(trace_dropped), 64'd2);
      while (exp_q.size() > 0) begin
         check("drain_valid", 64'(trace_valid), 64'd1);
         check("drain_data",  128'(trace_data), 128'(exp_q.pop_front()));
         tick();
      end
      check("drain_empty", 64'(trace_valid), 64'd0);

      // Halt edge with three records queued, then drain to DONE.
      trace_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h4000, 4'd1, 16'h1111);
      exp_q.push_back(mk(3'b001, 16'h0300, 16'h4000, 4'd1, 16'h1111));
      tick();
      drive(1'b1, 1'b0, 1'b0, 16'h0301, 16'h4001, 4'd2, 16'h2222);
      exp_q.push_back(mk(3'b001, 16'h0301, 16'h4001, 4'd2, 16'h2222));
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0302, 16'h4002, 4'd3, 16'h3333);
      exp_q.push_back(mk(3'b100, 16'h0302, 16'h4002, 4'd3, 16'h3333));
      tick();
      exp_run = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 16'h0400, 16'h5000, 4'd4, 16'h4444);
      tick();
      tick();
      check("halt_done_early", 64'(trace_done), 64'd0);
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("halt_pop_data", 128'(trace_data), 128'(exp_q.pop_front()));
         tick();
      end
      check("halt_no_extra", 64'(trace_valid), 64'd0);
      check("done_not_yet",  64'(trace_done),  64'd0);
      tick();
      check("done_rise", 64'(trace_done), 64'd1);
      tick();
      check("done_hold", 64'(trace_done), 64'd1);
      trace_enable = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      tick();
      check("done_to_idle", 64'(trace_done), 64'd0);

      // Re-enter RUN: drop count cleared, event in the fifth RUN cycle.
      trace_enable = 1'b1;
      tick();
      exp_run = 1'b1;
      run_cnt = 0;
      check("drop_cleared", 64'(trace_dropped), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      for (int i = 0; i < 4; i++) tick();
      check("halt_fall_no_rec", 64'(trace_valid), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 16'h0500, 16'h6000, 4'd5, 16'h5555);
      exp_rec = mk(3'b001, 16'h0500, 16'h6000, 4'd5, 16'h5555);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      check("stamp_rec", 128'(trace_data), 128'(exp_rec));
`ifdef TRACE_CYCLE_STAMP_EN
      check("stamp_value", 64'(trace_data[15:0]), 64'd4);
`endif
      tick();

      // Reset while draining discards everything at once.
      trace_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 16'h0600, 16'h7000, 4'd6, 16'h6666);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0601, 16'h7001, 4'd7, 16'h7777);
      tick();
      exp_run = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000);
      tick();
      check("pre_rst_valid", 64'(trace_valid), 64'd1);
      reset = 1'b0;
      #1;
      check("midrst_valid", 64'(trace_valid), 64'd0);
      check("midrst_data",  128'(trace_data), 128'd0);
      check("midrst_done",  64'(trace_done),  64'd0);
      tick();
      reset = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
